fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage: owns the program counter, drives the instruction ROM address,
//  and registers the returned word with its PC into the fetch->decode pipeline register.
//  Sits between the execute-stage redirect logic and the decoder; the ROM is external and
//  combinational.
// PARAMETERS
//  WIDTH     `WORD (32)               instruction/PC width in bits
//  ADDR_W    `INS_ADDRESS_SPACE (4)   ROM word-address width (16 words)
//  RESET_PC  32'h0000_0000            PC loaded at reset (byte address)
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  fetch_en       in   1       1 = fetching allowed; 0 = hold PC, insert no new words
//  rom_addr       out  ADDR_W  word address to ROM = pc[ADDR_W+1:2] (combinational from pc)
//  rom_data       in   WIDTH   ROM read data, valid in the same cycle as rom_addr
//  redirect_valid in   1       branch/jump taken; flush and load redirect_pc
//  redirect_pc    in   WIDTH   redirect target, byte address
//  if_valid       out  1       fetch->decode register holds an instruction
//  if_ready       in   1       decoder accepts this cycle
//  if_instr       out  WIDTH   registered instruction word
//  if_pc          out  WIDTH   byte PC of if_instr
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert handled upstream): pc=RESET_PC, if_valid=0,
//    if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC. Mid-operation reset discards all state.
//  - slot_free = !if_valid | if_ready.  fetch = fetch_en & slot_free & !redirect_valid.
//  - On fetch: if_instr<=rom_data, if_pc<=pc, if_valid<=1, pc<=pc+4. Latency PC->if_valid: 1 clk.
//    Back-to-back fetches sustain one instruction per cycle while if_ready=1.
//  - Stall (if_valid & !if_ready): if_instr/if_pc/if_valid and pc hold unchanged.
//  - fetch_en=0 with slot_free: if_valid<=0 (or stays 0), pc holds; held instr drains normally.
//  - Redirect has priority over fetch, stall and fetch_en: pc<={redirect_pc[WIDTH-1:2],2'b00},
//    if_valid<=0, if_instr/if_pc hold. Target fetched next cycle (redirect-to-valid: 2 clk).
//    Word presented with if_valid&if_ready at the redirect edge counts as handed over;
//    decoder/execute squash it.
//  - redirect_pc[1:0] ignored (forced to 0); no misalignment trap in this stage.
//  - PC arithmetic mod 2^WIDTH; rom_addr truncates, so fetch wraps every 2^ADDR_W words
//    (pc 0x3C -> 0x40 gives rom_addr 15 -> 0). pc 0xFFFF_FFFC+4 wraps to 0.
//  - No combinational path from if_ready or redirect_valid to any output; rom_addr depends
//    only on the pc register.
//  - Internal: pc reg, one pipeline register (valid, instr, pc); no state machine beyond
//    valid bit.
// STRUCTURE
//  - Shared package cpu_pkg: WORD, INS_ADDRESS_SPACE, RESET_PC, NOP_INSTR=32'h0000_0013,
//    typedef if_id_t {logic valid; logic [WORD-1:0] instr, pc;} reused by decode stage.
//  - One natural sub-module: pc_gen (pc register, +4 adder, redirect mux, hold logic);
//    the pipeline register stays in fetch_stage. ROM instantiated by the core top, not here.
// TESTING (bench ROM model: rom_data = 32'hA000_0000 | rom_addr)
//  1 Reset: hold rst_n=0 3 clk -> if_valid=0, if_instr=0x13, rom_addr=0; release, fetch_en=1,
//    if_ready=1 -> cycle 1 if_instr=0xA0000000 pc 0x0, then 0xA0000001 pc 0x4, ...
//  2 Stall: if_ready=0 while if_instr=0xA0000002 -> held 5 clk, rom_addr stays 3; if_ready=1
//    -> next word 0xA0000003, no word lost or duplicated.
//  3 Redirect: redirect_valid=1, redirect_pc=0x27 during stall -> next clk if_valid=0, pc=0x24;
//    following clk if_instr=0xA0000009, if_pc=0x24.
//  4 Wrap: start at pc=0x38 -> if_pc 0x38,0x3C,0x40 with if_instr 0xA000000E,0xA000000F,
//    0xA0000000.
//  5 fetch_en=0 for 4 clk mid-stream -> pipeline drains, if_valid=0, pc frozen; re-enable
//    resumes at the next sequential PC.
//  6 Async reset asserted mid-stall, between edges -> outputs return to reset values
//    immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/ROM sizing, reset PC, canonical NOP, fetch->decode payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int unsigned      WORD              = 32;
    localparam int unsigned      INS_ADDRESS_SPACE = 4;     // ROM word-address bits (16 words)
    localparam logic [WORD-1:0]  RESET_PC          = 32'h0000_0000;
    localparam logic [WORD-1:0]  NOP_INSTR         = 32'h0000_0013;  // addi x0, x0, 0

    // Payload of the fetch->decode pipeline register, shared with the decode stage.
    typedef struct packed {
        logic            valid;
        logic [WORD-1:0] instr;
        logic [WORD-1:0] pc;
    } if_id_t;

endpackage

// File: rtl/pc_gen.sv
// Program counter: reset load, sequential +4 advance, word-aligned redirect, otherwise hold.
// Latency: pc updates on the clock edge after advance/redirect is sampled.
// Backpressure: none internally; the caller only asserts advance when the next stage has room.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   advance         step pc by one word this cycle
//   redirect_valid  load redirect_pc (wins over advance)
//   redirect_pc     redirect target, byte address; low two bits discarded
//   pc              current program counter (registered)
module pc_gen #(
    parameter int unsigned            WIDTH    = cpu_pkg::WORD,
    parameter logic [WIDTH-1:0]       RESET_PC = WIDTH'(cpu_pkg::RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc
);
    import cpu_pkg::*;

    // Targets are forced to word alignment; the dropped bits are deliberately unused.
    logic [WIDTH-1:0] redirect_aligned;
    logic             unused_align;

    assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_align     = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_aligned;
        end else if (advance) begin
            pc <= pc + WIDTH'(4);   // wraps mod 2^WIDTH
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives ROM address from pc, registers returned word + pc toward decode.
// Latency: 1 clk pc->if_valid; 2 clk redirect->first valid target word.
// Backpressure: if_valid & !if_ready stalls pc and the output register; redirect overrides.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   fetch_en                    allow fetching; 0 lets the held word drain and freezes pc
//   rom_addr / rom_data         combinational ROM interface (word address from pc)
//   redirect_valid/redirect_pc  taken branch/jump: flush output register, reload pc
//   if_valid/if_ready           handshake to decode
//   if_instr/if_pc              registered instruction word and its byte pc
module fetch_stage #(
    parameter int unsigned      WIDTH    = cpu_pkg::WORD,
    parameter int unsigned      ADDR_W   = cpu_pkg::INS_ADDRESS_SPACE,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(cpu_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_data,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [WIDTH-1:0]  if_instr,
    output logic [WIDTH-1:0]  if_pc
);
    import cpu_pkg::*;

    logic [WIDTH-1:0] pc;
    logic             slot_free;
    logic             fetch;

    // The output slot can take a new word when it is empty or being drained this cycle.
    assign slot_free = !if_valid || if_ready;
    assign fetch     = fetch_en && slot_free && !redirect_valid;

    // Address comes straight from the pc register; upper pc bits are truncated so the
    // fetch stream wraps around the ROM.
    assign rom_addr  = pc[ADDR_W+1:2];

    pc_gen #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance        (fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc)
    );

    // Fetch->decode register. A redirect only clears valid; instr/pc keep their old
    // contents since the consumer ignores them while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_instr <= WIDTH'(NOP_INSTR);
            if_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (fetch) begin
            if_valid <= 1'b1;
            if_instr <= rom_data;
            if_pc    <= pc;
        end else if (slot_free) begin
            // fetch_en low with nothing left to hold: the slot empties.
            if_valid <= 1'b0;
        end
    end

endmodule
